// File: rtl/sram_dp_ana_if.sv
`default_nettype none
// ============================================================================
//  Module      : sram_dp_ana_if
//  Description : Bus interface for the dual-port analog-emulated SRAM.
//                Every signal is an ANA_WIDTH-bit emulated analog level;
//                multi-bit fields carry one level per logical bit.
//                Signals:
//                  we_a / waddr_a / din_a   write port   (master -> slave)
//                  re_a / raddr_a           read request (master -> slave)
//                  dout_a / rvalid_a        read return  (slave -> master)
//                  busy_a                   clear sweep busy, only when
//                                           SRAM_INIT_CLR_EN is defined
//  Revision    : 1.0 - initial release
// ============================================================================
interface sram_dp_ana_if #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 4,
  parameter int ANA_WIDTH  = 8
);
  logic [ANA_WIDTH-1:0]                  we_a;
  logic [ADDR_WIDTH-1:0][ANA_WIDTH-1:0]  waddr_a;
  logic [DATA_WIDTH-1:0][ANA_WIDTH-1:0]  din_a;
  logic [ANA_WIDTH-1:0]                  re_a;
  logic [ADDR_WIDTH-1:0][ANA_WIDTH-1:0]  raddr_a;
  logic [DATA_WIDTH-1:0][ANA_WIDTH-1:0]  dout_a;
  logic [ANA_WIDTH-1:0]                  rvalid_a;
`ifdef SRAM_INIT_CLR_EN
  logic [ANA_WIDTH-1:0]                  busy_a;

  modport master (output we_a, waddr_a, din_a, re_a, raddr_a,
                  input  dout_a, rvalid_a, busy_a);
  modport slave  (input  we_a, waddr_a, din_a, re_a, raddr_a,
                  output dout_a, rvalid_a, busy_a);
`else
  modport master (output we_a, waddr_a, din_a, re_a, raddr_a,
                  input  dout_a, rvalid_a);
  modport slave  (input  we_a, waddr_a, din_a, re_a, raddr_a,
                  output dout_a, rvalid_a);
`endif
endinterface
`default_nettype wire

// File: rtl/sram_dp_ana.sv
`default_nettype none
// ============================================================================
//  Module      : sram_dp_ana
//  Description : Dual-port SRAM with emulated analog pins. Inputs pass
//                through per-bit hysteresis comparators, reads go through a
//                RD_LATENCY-deep pipeline with a one-cycle valid strobe, and
//                a same-address write/read on one edge is write-first.
//                Ports:
//                  clk_a    clock level, digitised at FULL_SCALE/2
//                  rst_n_a  async active-low reset level, same midpoint
//                  bus      sram_dp_ana_if.slave (write/read/return pins)
//                Optional macro SRAM_INIT_CLR_EN: adds busy_a and a
//                post-reset sweep that zeroes the whole array.
//  Revision    : 1.0 - initial release
// ============================================================================
module sram_dp_ana #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 4,
  parameter int ANA_WIDTH  = 8,
  parameter int FULL_SCALE = 255,
  parameter int V_TH_HI    = 170,
  parameter int V_TH_LO    = 85,
  parameter int RD_LATENCY = 1
) (
  input  logic [ANA_WIDTH-1:0] clk_a,
  input  logic [ANA_WIDTH-1:0] rst_n_a,
  sram_dp_ana_if.slave         bus
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;
  // din at [DW-1:0], raddr above, then waddr, re, we at the top.
  localparam int NIN   = 2 + 2 * ADDR_WIDTH + DATA_WIDTH;

  localparam logic [ANA_WIDTH-1:0] C_MID = ANA_WIDTH'(FULL_SCALE / 2);
  localparam logic [ANA_WIDTH-1:0] C_FS  = ANA_WIDTH'(FULL_SCALE);
  localparam logic [ANA_WIDTH-1:0] C_HI  = ANA_WIDTH'(V_TH_HI);
  localparam logic [ANA_WIDTH-1:0] C_LO  = ANA_WIDTH'(V_TH_LO);

  logic clk_d;
  logic rst_n_d;
  assign clk_d   = (clk_a > C_MID);
  assign rst_n_d = (rst_n_a > C_MID);

  // --------------------------------------------------------------------------
  // Hysteresis comparators: the freshly digitised value is used on this edge
  // and also becomes the remembered value for the next one.
  // --------------------------------------------------------------------------
  logic [NIN-1:0][ANA_WIDTH-1:0] in_lvl;
  logic [NIN-1:0]                hyst_q, hyst_d;

  assign in_lvl = {bus.we_a, bus.re_a, bus.waddr_a, bus.raddr_a, bus.din_a};

  for (genvar i = 0; i < NIN; i++) begin : g_hyst
    assign hyst_d[i] = (in_lvl[i] >= C_HI) ? 1'b1 :
                       (in_lvl[i] <= C_LO) ? 1'b0 : hyst_q[i];
  end

  logic [DATA_WIDTH-1:0] w_din;
  logic [ADDR_WIDTH-1:0] w_raddr, w_waddr;
  logic                  w_re, w_we;
  assign w_din   = hyst_d[DATA_WIDTH-1:0];
  assign w_raddr = hyst_d[DATA_WIDTH +: ADDR_WIDTH];
  assign w_waddr = hyst_d[DATA_WIDTH + ADDR_WIDTH +: ADDR_WIDTH];
  assign w_re    = hyst_d[NIN-2];
  assign w_we    = hyst_d[NIN-1];

  // --------------------------------------------------------------------------
  // Write-port arbitration (clear sweep owns the array while busy)
  // --------------------------------------------------------------------------
  logic                  wr_en;
  logic [ADDR_WIDTH-1:0] wr_addr;
  logic [DATA_WIDTH-1:0] wr_data;
  logic                  rd_req;

`ifdef SRAM_INIT_CLR_EN
  typedef enum logic [1:0] {ST_IDLE, ST_CLEAR, ST_READY} state_t;
  state_t                state_q, state_d;
  logic [ADDR_WIDTH-1:0] clr_cnt_q, clr_cnt_d;
  logic                  clr_we;
  logic                  busy;

  // IDLE is the reset state; its first edge already clears address 0, so the
  // sweep covers DEPTH edges in total before READY.
  always_comb begin
    state_d   = state_q;
    clr_cnt_d = clr_cnt_q;
    clr_we    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        clr_we    = 1'b1;
        clr_cnt_d = clr_cnt_q + 1'b1;
        state_d   = ST_CLEAR;
      end
      ST_CLEAR: begin
        clr_we    = 1'b1;
        clr_cnt_d = clr_cnt_q + 1'b1;
        if (&clr_cnt_q) state_d = ST_READY;
      end
      default: state_d = ST_READY;
    endcase
  end

  always_ff @(posedge clk_d or negedge rst_n_d) begin
    if (!rst_n_d) begin
      state_q   <= ST_IDLE;
      clr_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      clr_cnt_q <= clr_cnt_d;
    end
  end

  assign busy       = (state_q != ST_READY);
  assign bus.busy_a = busy ? C_FS : '0;
  assign wr_en      = busy ? clr_we    : w_we;
  assign wr_addr    = busy ? clr_cnt_q : w_waddr;
  assign wr_data    = busy ? '0        : w_din;
  assign rd_req     = w_re & ~busy;
`else
  assign wr_en   = w_we;
  assign wr_addr = w_waddr;
  assign wr_data = w_din;
  assign rd_req  = w_re;
`endif

  // --------------------------------------------------------------------------
  // Storage array (not reset: contents survive rst_n)
  // --------------------------------------------------------------------------
  logic [DATA_WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk_d) begin
    if (wr_en) mem[wr_addr] <= wr_data;
  end

  // Write-first: a same-edge write to the read address is forwarded.
  logic [DATA_WIDTH-1:0] rd_word;
  assign rd_word = (wr_en && (wr_addr == w_raddr)) ? wr_data : mem[w_raddr];

  // --------------------------------------------------------------------------
  // Read pipeline. The last stage doubles as the output register and holds
  // its data when nothing completes.
  // --------------------------------------------------------------------------
  logic [RD_LATENCY-1:0]                 vld_q, vld_d;
  logic [RD_LATENCY-1:0][DATA_WIDTH-1:0] dat_q, dat_d;

  always_comb begin
    vld_d    = '0;
    dat_d    = dat_q;
    vld_d[0] = rd_req;
    dat_d[0] = rd_word;
    for (int i = 1; i < RD_LATENCY; i++) begin
      vld_d[i] = vld_q[i-1];
      dat_d[i] = dat_q[i-1];
    end
    if (!vld_d[RD_LATENCY-1]) dat_d[RD_LATENCY-1] = dat_q[RD_LATENCY-1];
  end

  always_ff @(posedge clk_d or negedge rst_n_d) begin
    if (!rst_n_d) begin
      hyst_q <= '0;
      vld_q  <= '0;
      dat_q  <= '0;
    end else begin
      hyst_q <= hyst_d;
      vld_q  <= vld_d;
      dat_q  <= dat_d;
    end
  end

  for (genvar i = 0; i < DATA_WIDTH; i++) begin : g_dout
    assign bus.dout_a[i] = dat_q[RD_LATENCY-1][i] ? C_FS : '0;
  end
  assign bus.rvalid_a = vld_q[RD_LATENCY-1] ? C_FS : '0;

endmodule
`default_nettype wire

// File: tb/tb_sram_dp_ana.sv
`default_nettype none
// ============================================================================
//  Module      : tb_sram_dp_ana
//  Description : Bench for sram_dp_ana. Two instances (read latency 1 and 3)
//                share clock, reset and stimulus. A history-based model
//                predicts both outputs every cycle; literal checks pin it.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_sram_dp_ana;

  logic       clk = 1'b0;
  logic [7:0] clk_a;
  logic [7:0] rst_n_a;

  always #5 clk = ~clk;
  assign clk_a = clk ? 8'd220 : 8'd20;

  sram_dp_ana_if #(.DATA_WIDTH(8), .ADDR_WIDTH(4), .ANA_WIDTH(8)) bus1 ();
  sram_dp_ana_if #(.DATA_WIDTH(8), .ADDR_WIDTH(4), .ANA_WIDTH(8)) bus3 ();

  sram_dp_ana #(.RD_LATENCY(1)) u_dut1 (.clk_a(clk_a), .rst_n_a(rst_n_a), .bus(bus1.slave));
  sram_dp_ana #(.RD_LATENCY(3)) u_dut3 (.clk_a(clk_a), .rst_n_a(rst_n_a), .bus(bus3.slave));

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [7:0][7:0] in_lv(input logic [7:0] w);
    for (int i = 0; i < 8; i++) in_lv[i] = w[i] ? 8'd230 : 8'd15;
  endfunction

  function automatic logic [3:0][7:0] in_lv4(input logic [3:0] w);
    for (int i = 0; i < 4; i++) in_lv4[i] = w[i] ? 8'd230 : 8'd15;
  endfunction

  function automatic logic [7:0][7:0] out_lv(input logic [7:0] w);
    for (int i = 0; i < 8; i++) out_lv[i] = w[i] ? 8'd255 : 8'd0;
  endfunction

  function automatic bit dig(input logic [7:0] l, input bit prev);
    if (l >= 8'd170) return 1'b1;
    if (l <= 8'd85)  return 1'b0;
    return prev;
  endfunction

  // ---------------- model ----------------
  logic [7:0] mem_m [16];
  bit         ev [4096];
  logic [7:0] ed [4096];
  int         ecount = 0;
  int         epoch  = 0;
  bit         exp_v [2];
  logic [7:0] exp_d [2];
  bit         h_we, h_re;
  bit [3:0]   h_wa, h_ra;
  bit [7:0]   h_d;
  int         busy_left = 0;

  task automatic model_reset();
    epoch = ecount;
    for (int l = 0; l < 2; l++) begin exp_v[l] = 1'b0; exp_d[l] = 8'h00; end
    h_we = 0; h_re = 0; h_wa = 0; h_ra = 0; h_d = 0;
`ifdef SRAM_INIT_CLR_EN
    busy_left = 16;
    for (int a = 0; a < 16; a++) mem_m[a] = 8'h00;
`endif
  endtask

  task automatic model_edge();
    bit we, re;
    logic [7:0] word;
    h_we = dig(bus1.we_a, h_we);
    h_re = dig(bus1.re_a, h_re);
    for (int i = 0; i < 4; i++) begin
      h_wa[i] = dig(bus1.waddr_a[i], h_wa[i]);
      h_ra[i] = dig(bus1.raddr_a[i], h_ra[i]);
    end
    for (int i = 0; i < 8; i++) h_d[i] = dig(bus1.din_a[i], h_d[i]);
    we = h_we; re = h_re;
    if (busy_left > 0) begin busy_left--; we = 0; re = 0; end
    word = (we && h_wa == h_ra) ? h_d : mem_m[h_ra];
    ev[ecount] = re;
    ed[ecount] = word;
    if (we) mem_m[h_wa] = h_d;
    for (int l = 0; l < 2; l++) begin
      int k;
      k = ecount - ((l == 0) ? 1 : 3) + 1;
      exp_v[l] = (k >= epoch) && ev[k];
      if (exp_v[l]) exp_d[l] = ed[k];
    end
    ecount++;
  endtask

  initial begin
    forever begin
      @(posedge clk);
      if (rst_n_a > 8'd127) model_edge();
      else                  model_reset();
      #1;
      check("dout_l1",   bus1.dout_a,   out_lv(exp_d[0]));
      check("rvalid_l1", bus1.rvalid_a, exp_v[0] ? 8'd255 : 8'd0);
      check("dout_l3",   bus3.dout_a,   out_lv(exp_d[1]));
      check("rvalid_l3", bus3.rvalid_a, exp_v[1] ? 8'd255 : 8'd0);
`ifdef SRAM_INIT_CLR_EN
      check("busy_m", bus1.busy_a, (rst_n_a <= 8'd127 || busy_left > 0) ? 8'd255 : 8'd0);
`endif
    end
  end

  // ---------------- stimulus ----------------
  task automatic step(input bit we, input logic [3:0] wa, input logic [7:0][7:0] dl,
                      input bit re, input logic [3:0] ra);
    bus1.we_a = we ? 8'd230 : 8'd15;  bus3.we_a = bus1.we_a;
    bus1.re_a = re ? 8'd230 : 8'd15;  bus3.re_a = bus1.re_a;
    bus1.waddr_a = in_lv4(wa);        bus3.waddr_a = bus1.waddr_a;
    bus1.raddr_a = in_lv4(ra);        bus3.raddr_a = bus1.raddr_a;
    bus1.din_a = dl;                  bus3.din_a = dl;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idle();
    step(1'b0, 4'd0, in_lv(8'h00), 1'b0, 4'd0);
  endtask

  task automatic wait_ready();
`ifdef SRAM_INIT_CLR_EN
    for (int i = 0; i < 16; i++) begin
      check("busy_hi", bus1.busy_a, 8'd255);
      step(1'b0, 4'd0, in_lv(8'h00), 1'b1, 4'd9);
      check("busy_no_rvalid", bus1.rvalid_a, 8'd0);
    end
    check("busy_lo", bus1.busy_a, 8'd0);
`endif
  endtask

  initial begin
    logic [7:0][7:0] dl;
    logic [7:0]      v77;
    rst_n_a = 8'd0;
    step(1'b0, 4'd0, in_lv(8'h00), 1'b0, 4'd0);
    check("rst_dout", bus1.dout_a, out_lv(8'h00));
    check("rst_rvalid", bus3.rvalid_a, 8'd0);
    idle();
    rst_n_a = 8'd240;
    wait_ready();

    // Latency 1 sweep
    for (int i = 0; i < 16; i++) step(1'b1, 4'(i), in_lv(8'(i)), 1'b0, 4'd0);
    for (int i = 0; i < 16; i++) begin
      step(1'b0, 4'd0, in_lv(8'h00), 1'b1, 4'(i));
      check("l1_dout", bus1.dout_a, out_lv(8'(i)));
      check("l1_rvalid", bus1.rvalid_a, 8'd255);
    end
    idle();
    check("l1_rvalid_off", bus1.rvalid_a, 8'd0);
    check("l1_hold", bus1.dout_a, out_lv(8'd15));

    // Latency 3 pipeline
    step(1'b1, 4'd2, in_lv(8'hA5), 1'b0, 4'd0);
    step(1'b1, 4'd5, in_lv(8'h3C), 1'b0, 4'd0);
    step(1'b1, 4'd7, in_lv(8'hFF), 1'b0, 4'd0);
    step(1'b0, 4'd0, in_lv(8'h00), 1'b1, 4'd2);
    check("l1_a5", bus1.dout_a, out_lv(8'hA5));
    check("l3_early", bus3.rvalid_a, 8'd0);
    step(1'b0, 4'd0, in_lv(8'h00), 1'b1, 4'd5);
    step(1'b0, 4'd0, in_lv(8'h00), 1'b1, 4'd7);
    check("l3_a5", bus3.dout_a, out_lv(8'hA5));
    check("l3_v0", bus3.rvalid_a, 8'd255);
    idle();
    check("l3_3c", bus3.dout_a, out_lv(8'h3C));
    check("l3_v1", bus3.rvalid_a, 8'd255);
    idle();
    check("l3_ff", bus3.dout_a, out_lv(8'hFF));
    check("l3_v2", bus3.rvalid_a, 8'd255);
    idle();
    check("l3_off", bus3.rvalid_a, 8'd0);
    check("l3_hold", bus3.dout_a, out_lv(8'hFF));

    // Hysteresis on din bit0: 200 -> 1, 128 -> keeps 1, 60 -> 0
    dl = in_lv(8'h00); dl[0] = 8'd200;
    step(1'b1, 4'd1, dl, 1'b1, 4'd1);
    check("hyst_200", bus1.dout_a, out_lv(8'h01));
    dl[0] = 8'd128;
    step(1'b1, 4'd1, dl, 1'b1, 4'd1);
    check("hyst_128", bus1.dout_a, out_lv(8'h01));
    dl[0] = 8'd60;
    step(1'b1, 4'd1, dl, 1'b1, 4'd1);
    check("hyst_60", bus1.dout_a, out_lv(8'h00));
    check("model_mem1", mem_m[1], 8'h00);

    // Same-edge write/read bypass
    step(1'b1, 4'd4, in_lv(8'h5A), 1'b1, 4'd4);
    check("bypass", bus1.dout_a, out_lv(8'h5A));

    // Reset during an in-flight latency-3 read
`ifdef SRAM_INIT_CLR_EN
    v77 = 8'h00;
`else
    v77 = 8'h77;
`endif
    step(1'b1, 4'd3, in_lv(8'h77), 1'b0, 4'd0);
    step(1'b0, 4'd0, in_lv(8'h00), 1'b1, 4'd3);
    check("pre_rst_l1", bus1.dout_a, out_lv(8'h77));
    idle();
    rst_n_a = 8'd0;
    #1;
    check("rst_l3_dout", bus3.dout_a, out_lv(8'h00));
    check("rst_l3_rvalid", bus3.rvalid_a, 8'd0);
    check("rst_l1_dout", bus1.dout_a, out_lv(8'h00));
    @(negedge clk);
    idle();
    idle();
    rst_n_a = 8'd240;
    wait_ready();
    for (int i = 0; i < 3; i++) begin
      idle();
      check("no_stale_rvalid", bus3.rvalid_a, 8'd0);
    end
    // 128 right after reset digitises as 0; bit7 is solid high
    dl = in_lv(8'h80); dl[0] = 8'd128;
    step(1'b1, 4'd2, dl, 1'b1, 4'd2);
    check("hyst_post_rst", bus1.dout_a, out_lv(8'h80));
    step(1'b0, 4'd0, in_lv(8'h00), 1'b1, 4'd3);
    check("retain_l1", bus1.dout_a, out_lv(v77));
    idle();
    idle();
    check("retain_l3", bus3.dout_a, out_lv(v77));
    check("retain_l3_v", bus3.rvalid_a, 8'd255);

`ifdef SRAM_INIT_CLR_EN
    step(1'b1, 4'd9, in_lv(8'hFF), 1'b0, 4'd0);
    rst_n_a = 8'd0;
    idle();
    rst_n_a = 8'd240;
    wait_ready();
    step(1'b0, 4'd0, in_lv(8'h00), 1'b1, 4'd9);
    check("clr_addr9", bus1.dout_a, out_lv(8'h00));
    check("clr_rvalid", bus1.rvalid_a, 8'd255);
`endif

    idle();
    idle();
    idle();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/sram_dp_ana.md
Name: sram_dp_ana

Overview:
- Parametrised successor to the single-port analog-emulated SRAM.
- Separate write and read ports, configurable read latency with a valid strobe, and input comparators with hysteresis.
- All pins are ANA_WIDTH-bit "analog" levels. Internal logic is digital, clocked on the digitised clock.
- Sits between analog-emulated stimulus/PHY models and digital consumers in the mixed-signal SRAM macro.

Parameters:
- DATA_WIDTH, 8, bits per word.
- ADDR_WIDTH, 4, address bits; DEPTH = 2**ADDR_WIDTH.
- ANA_WIDTH, 8, resolution of each emulated analog level.
- FULL_SCALE, 255, logic-1 drive level; must be < 2**ANA_WIDTH.
- V_TH_HI, 170, input level at or above which a bit reads 1.
- V_TH_LO, 85, input level at or below which a bit reads 0; V_TH_LO < V_TH_HI required.
- RD_LATENCY, 1, clock edges from read request to valid data; legal range 1..4.

Ports:
- clk_a  in  ANA_WIDTH  clock level; clk_d = (clk_a > FULL_SCALE/2); logic runs on posedge clk_d.
- rst_n_a  in  ANA_WIDTH  reset level; rst_n_d = (rst_n_a > FULL_SCALE/2); asynchronous, active-low.
- we_a  in  ANA_WIDTH  write enable.
- waddr_a  in  ADDR_WIDTH x ANA_WIDTH  write address, one level per bit.
- din_a  in  DATA_WIDTH x ANA_WIDTH  write data, one level per bit.
- re_a  in  ANA_WIDTH  read enable.
- raddr_a  in  ADDR_WIDTH x ANA_WIDTH  read address.
- dout_a  out  DATA_WIDTH x ANA_WIDTH  read data, each bit driven 0 or FULL_SCALE.
- rvalid_a  out  ANA_WIDTH  FULL_SCALE for one cycle when dout_a carries new read data.

Behaviour:
- Clock and reset use a fixed midpoint comparator, strictly greater than FULL_SCALE/2.
- Reset is asynchronous on negedge rst_n_d. While rst_n_d = 0:
  - all hysteresis state = 0;
  - read pipeline flushed;
  - dout_a all 0, rvalid_a = 0.
- Memory array is not cleared by reset unless SRAM_INIT_CLR_EN is defined.
- Every control, address and data bit passes through a hysteresis comparator sampled at posedge clk_d:
  - level >= V_TH_HI gives 1;
  - level <= V_TH_LO gives 0;
  - otherwise the bit keeps that bit's previous digitised value.
  - The new digitised value is used in the same edge and stored for the next edge.
- Write: at posedge with we = 1, mem[waddr] <= din. No write latency beyond that edge.
- Read: re = 1 at edge N launches a request. The pipeline is RD_LATENCY stages deep; stage 0 captures mem[raddr] at edge N.
  - After edge N+RD_LATENCY-1, dout_a shows the word and rvalid_a = FULL_SCALE for exactly one cycle.
  - With RD_LATENCY = 1, data is visible right after edge N.
- Back-to-back reads: one request accepted per edge, fully pipelined, no bubbles.
- rvalid_a deasserts when no request completes.
- dout_a holds its last value when rvalid_a = 0.
- Simultaneous write and read, same address, same edge: write-first. The read returns the new din (bypass).
- Different addresses are independent.
- Reset asserted mid-read: in-flight requests are dropped. No rvalid_a pulse after reset release for requests issued before reset.
- Out-of-range values are impossible: the address width covers the full DEPTH.

Optional Feature:
- Macro SRAM_INIT_CLR_EN.
- Defined:
  - Extra output busy_a (ANA_WIDTH).
  - After reset release, FSM IDLE->CLEAR->READY. CLEAR writes 0 to addresses 0..DEPTH-1, one per edge, so it lasts DEPTH cycles.
  - busy_a = FULL_SCALE during reset and CLEAR.
  - Writes and reads are ignored while busy: no rvalid_a pulse.
  - Reset during CLEAR restarts the sweep from address 0.
- Undefined: no busy_a port; array contents are retained across reset and undefined at power-up.

Test Plan:
- RD_LATENCY=1: write addr i with data i for i=0..15, then read 0..15 -> dout = i, rvalid_a = 255 one cycle after each request.
- RD_LATENCY=3: issue reads to 2, 5, 7 on consecutive edges after writing 0xA5, 0x3C, 0xFF -> rvalid on edges N+2, N+3, N+4 with data 0xA5, 0x3C, 0xFF.
- Hysteresis: din bit0 driven 200 then 128 then 60 on three writes to addr 1 -> stored bit0 = 1, 1, 0. A level of 128 after reset reads 0.
- Same-edge write 0x5A and read of addr 4 -> dout = 0x5A.
- Reset asserted (rst_n_a = 0) one cycle after a read with RD_LATENCY=3 -> dout = 0, no rvalid pulse. Data previously written at addr 3 (0x77) still reads 0x77 afterwards (macro undefined).
- SRAM_INIT_CLR_EN: write 0xFF to addr 9, reset -> busy_a = 255 for 16 cycles; a read issued during busy gives no rvalid; afterwards addr 9 reads 0x00.
